// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constants and round-constant lookup for the AES-128 key schedule.
package aes_pkg;
    localparam int AES_NR = 10;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_key_t;
    typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_e;

    localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [7:0] rcon_of(input logic [3:0] i);
        return (i >= 4'd1 && i <= 4'd10) ? RCON[i] : 8'h00;
    endfunction
endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key-schedule step, forward (dir=0) or inverse (dir=1),
// sharing a single SubWord between both directions.
module aes_key_step
    import aes_pkg::*;
(
    input  aes_key_t   key,
    input  logic [7:0] rcon,
    input  logic       dir,
    output aes_key_t   key_nxt
);
    aes_word_t  w0, w1, w2, w3, sin, rot, sub, t;
    aes_word_t  n0, n1, n2, n3;
    logic [7:0] sb [4];

    assign {w0, w1, w2, w3} = key;
    // inverse recovers the previous w3 first, which then feeds the S-box
    assign sin = dir ? w3 ^ w2 : w3;
    assign rot = {sin[23:0], sin[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.x(rot[8*i +: 8]), .y(sb[i]));
    end

    assign sub = {sb[3], sb[2], sb[1], sb[0]};
    assign t   = sub ^ {rcon, 24'h0};

    always_comb begin
        n0 = w0 ^ t;
        n1 = dir ? w1 ^ w0 : w1 ^ n0;
        n2 = dir ? w2 ^ w1 : w2 ^ n1;
        n3 = dir ? w3 ^ w2 : w3 ^ n2;
    end

    assign key_nxt = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box, table lookup.
module aes_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);
    // row 0 sits in the top bits, so entry x lives at bit offset 8*(255-x)
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [7:0] r;

    assign r = ~x;
    assign y = SBOX[{r, 3'b000} +: 8];
endmodule

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: sequential AES-128 decryption key scheduler; expands to the
// round-10 key, then streams round keys 10..0 over a valid/ready handshake.
module aes_inv_key_sched
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS  = 10,
    parameter int AUTO_REWIND = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         pass_done
);
    if (NUM_ROUNDS != AES_NR) begin : g_bad_rounds
        $error("aes_inv_key_sched supports only NUM_ROUNDS=10");
    end

    state_e     state_q, state_d;
    aes_key_t   key_q, key_d, rk10_q, rk10_d, step_key;
    logic [3:0] rcnt_q, rcnt_d, ridx;
    logic       done_q, done_d;

    // forward steps use Rcon[rcnt+1], inverse steps use Rcon[rcnt]
    assign ridx = (state_q == EXPAND) ? rcnt_q + 4'd1 : rcnt_q;

    aes_key_step u_step (
        .key    (key_q),
        .rcon   (rcon_of(ridx)),
        .dir    (state_q == STREAM),
        .key_nxt(step_key)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rk10_d  = rk10_q;
        rcnt_d  = rcnt_q;
        done_d  = 1'b0;
        if (key_load) begin
            key_d   = key_in;
            rcnt_d  = 4'd0;
            state_d = EXPAND;
        end else if (state_q == EXPAND) begin
            key_d  = step_key;
            rcnt_d = rcnt_q + 4'd1;
            if (rcnt_q == 4'd9) begin
                rk10_d  = step_key;
                state_d = STREAM;
            end
        end else if (state_q == STREAM && rk_ready) begin
            if (rcnt_q != 4'd0) begin
                key_d  = step_key;
                rcnt_d = rcnt_q - 4'd1;
            end else begin
                done_d = 1'b1;
                if (AUTO_REWIND != 0) begin
                    key_d  = rk10_q;
                    rcnt_d = 4'd10;
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            rk10_q  <= '0;
            rcnt_q  <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rk10_q  <= rk10_d;
            rcnt_q  <= rcnt_d;
            done_q  <= done_d;
        end
    end

    // outputs are qualified by state so nothing leaks while expanding or idle
    assign busy      = (state_q == EXPAND);
    assign rk_valid  = (state_q == STREAM);
    assign rk_out    = rk_valid ? key_q : '0;
    assign rk_round  = rk_valid ? rcnt_q : 4'd0;
    assign pass_done = done_q;
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb_aes_inv_key_sched: directed checks of the inverse key scheduler against FIPS-197 round keys.
module tb_aes_inv_key_sched;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_load = 1'b0, key_load0 = 1'b0;
    logic [127:0] key_in = '0, key_in0 = '0;
    logic         rk_ready = 1'b0, rk_ready0 = 1'b0;
    logic         busy, rk_valid, pass_done, busy0, rk_valid0, pass_done0;
    logic [127:0] rk_out, rk_out0;
    logic [3:0]   rk_round, rk_round0;

    int total = 0;
    int bad = 0;

    logic [127:0] a1 [0:10];
    localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_inv_key_sched #(.NUM_ROUNDS(10), .AUTO_REWIND(1)) dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
        .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
        .rk_round(rk_round), .pass_done(pass_done)
    );

    aes_inv_key_sched #(.NUM_ROUNDS(10), .AUTO_REWIND(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .key_load(key_load0), .key_in(key_in0),
        .busy(busy0), .rk_valid(rk_valid0), .rk_ready(rk_ready0), .rk_out(rk_out0),
        .rk_round(rk_round0), .pass_done(pass_done0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!rk_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic load(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
    endtask

    initial begin
        int n, exp_r, cyc, pd_seen, v_seen;
        bit rdy, fin;
        a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", rk_valid, 0);
        chk("rst_out", rk_out, 0);
        chk("rst_round", rk_round, 0);
        chk("rst_done", pass_done, 0);
        #10 rst_n = 1'b1;
        step();

        // FIPS-197 A.1 key, full pass with rk_ready held high
        rk_ready = 1'b1;
        load(a1[0]);
        chk("a1_busy", busy, 1);
        chk("a1_valid_low", rk_valid, 0);
        wait_valid(n);
        chk("a1_latency", n, 10);
        chk("a1_round10", rk_round, 10);
        chk("a1_rk10", rk_out, a1[10]);
        chk("a1_busy_stream", busy, 0);
        for (int r = 9; r >= 0; r--) begin
            step();
            chk("a1_round", rk_round, r);
            chk("a1_rk", rk_out, a1[r]);
            chk("a1_done_low", pass_done, 0);
        end
        step();
        rk_ready = 1'b0;
        chk("a1_pass_done", pass_done, 1);
        chk("a1_rewind_round", rk_round, 10);
        chk("a1_rewind_rk", rk_out, a1[10]);
        step();
        chk("a1_done_pulse", pass_done, 0);
        chk("a1_hold_round", rk_round, 10);
        chk("a1_hold_valid", rk_valid, 1);

        // random throttling through one full pass
        exp_r = 10;
        fin = 0;
        cyc = 0;
        while (!fin && cyc < 300) begin
            rdy = 1'($urandom_range(0, 1));
            rk_ready = rdy;
            step();
            cyc++;
            chk("thr_done", pass_done, rdy && exp_r == 0);
            if (rdy) begin
                if (exp_r == 0) begin
                    fin = 1;
                    exp_r = 10;
                end else begin
                    exp_r--;
                end
            end
            chk("thr_round", rk_round, exp_r);
            chk("thr_rk", rk_out, a1[exp_r]);
        end
        chk("thr_finished", fin, 1);

        // second key, checks round 10, round 0 and auto rewind
        rk_ready = 1'b0;
        load(K2);
        wait_valid(n);
        chk("k2_latency", n, 10);
        chk("k2_rk10", rk_out, K2R10);
        rk_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("k2_round0", rk_round, 0);
        chk("k2_rk0", rk_out, K2);
        step();
        rk_ready = 1'b0;
        chk("k2_pass_done", pass_done, 1);
        chk("k2_rewind_round", rk_round, 10);
        chk("k2_rewind_rk", rk_out, K2R10);
        step();
        chk("k2_done_pulse", pass_done, 0);

        // reload during EXPAND cycle 5
        load(a1[0]);
        for (int i = 0; i < 4; i++) step();
        chk("mid_exp_busy", busy, 1);
        load(K2);
        wait_valid(n);
        chk("mid_exp_latency", n, 10);
        chk("mid_exp_rk10", rk_out, K2R10);

        // reload mid-STREAM at round 4, coinciding with a handshake
        rk_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("mid_str_round4", rk_round, 4);
        pd_seen = 0;
        load(a1[0]);
        chk("mid_str_busy", busy, 1);
        chk("mid_str_valid", rk_valid, 0);
        n = 0;
        while (!rk_valid && n < 20) begin
            pd_seen += int'(pass_done);
            step();
            n++;
        end
        chk("mid_str_latency", n, 10);
        chk("mid_str_no_done", pd_seen, 0);
        chk("mid_str_rk10", rk_out, a1[10]);

        // async reset asserted off the clock edge mid-stream
        step();
        step();
        chk("pre_rst_round", rk_round, 8);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", rk_valid, 0);
        chk("arst_out", rk_out, 0);
        chk("arst_round", rk_round, 0);
        chk("arst_busy", busy, 0);
        #2 rst_n = 1'b1;
        v_seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            v_seen += int'(rk_valid) + int'(busy);
        end
        chk("post_rst_idle", v_seen, 0);
        rk_ready = 1'b0;

        // AUTO_REWIND=0 instance
        rk_ready0 = 1'b1;
        key_in0   = a1[0];
        key_load0 = 1'b1;
        step();
        key_load0 = 1'b0;
        n = 0;
        while (!rk_valid0 && n < 20) begin
            step();
            n++;
        end
        chk("nr_latency", n, 10);
        chk("nr_rk10", rk_out0, a1[10]);
        for (int i = 0; i < 10; i++) step();
        chk("nr_rk0", rk_out0, a1[0]);
        step();
        chk("nr_pass_done", pass_done0, 1);
        chk("nr_valid_low", rk_valid0, 0);
        chk("nr_busy_low", busy0, 0);
        chk("nr_out_zero", rk_out0, 0);
        v_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            v_seen += int'(rk_valid0) + int'(pass_done0) + int'(busy0);
        end
        chk("nr_stays_idle", v_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
Sequential AES-128 key scheduler for the decryption datapath. It runs the other direction of the forward key expansion. On key load it iterates the forward schedule once per cycle to reach the round-10 key. It then streams round keys in reverse order (10, 9, ... 0) to the inverse-cipher core over a valid/ready handshake, using one shared S-box word per cycle instead of 40 unrolled S-boxes.

Parameters:
NUM_ROUNDS, 10, AES round count; only 10 (AES-128) is supported, and any other value is a compile-time error.
AUTO_REWIND, 1, 1: after round 0 is accepted, reload the saved round-10 key and stream again; 0: return to IDLE.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
key_load  input  1  one-cycle strobe; capture key_in and start expansion
key_in  input  128  cipher key, word 0 = [127:96]
busy  output  1  high while in EXPAND
rk_valid  output  1  rk_out/rk_round hold a valid round key
rk_ready  input  1  consumer accepts the key when rk_valid && rk_ready at a clock edge
rk_out  output  128  current round key, same word ordering as key_in
rk_round  output  4  round index of rk_out (10 down to 0)
pass_done  output  1  one-cycle pulse, registered, when round 0 is accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, rk_valid=0, rk_out=0, rk_round=0, pass_done=0; saved-key register cleared.
- States: IDLE, EXPAND, STREAM. rk_valid is 1 only in STREAM; busy is 1 only in EXPAND.
- key_load has top priority in every state, including mid-EXPAND and mid-STREAM.
  - On the load edge: key reg <= key_in, rcnt <= 0, state <= EXPAND.
  - Any in-flight stream is abandoned with no pass_done.
- EXPAND: each edge applies the forward step with Rcon[rcnt+1]:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,24'h0}
  - w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
  - rcnt increments on each step.
  - On the step producing rcnt=10: save the key to the rk10 register and set state <= STREAM.
  - Latency: rk_valid rises exactly 10 clock edges after the load edge.
- STREAM: rk_out = key reg, rk_round = rcnt.
  - On handshake with rcnt>0: apply the inverse step with Rcon[rcnt]:
    - w3' = w3 ^ w2; w2' = w2 ^ w1; w1' = w1 ^ w0
    - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon,24'h0}
    - rcnt decrements; rk_valid stays 1. Zero-bubble: one key per cycle while rk_ready=1.
  - On handshake with rcnt=0: pass_done=1 next cycle.
    - AUTO_REWIND=1: key <= rk10, rcnt <= 10, rk_valid stays 1.
    - AUTO_REWIND=0: state <= IDLE, rk_valid <= 0.
  - rk_ready=0: rk_out and rk_round hold stable; no state change.
- key_load in the same cycle as a handshake: the load wins, and the handshake is not counted (no pass_done).
- Rcon table: 01,02,04,08,10,20,40,80,1B,36 for indices 1..10. Indices 0 and >10 are unreachable.
- rk_round never leaves the range 0..10.
- All outputs are registered or decoded directly from state; there is no combinational path from rk_ready or key_load to any output.

Decomposition:
- Package aes_pkg holds:
  - constants AES_NR=10 and the RCON[1:10] table;
  - typedef aes_word_t (32b);
  - typedef aes_key_t (128b);
  - state enum {IDLE, EXPAND, STREAM}.
- Sub-module aes_key_step (combinational) provides both directions.
  - Inputs: key, rcon, dir. Output: next key.
  - It instantiates the existing sbox four times on one shared word.
  - dir selects the sbox input (w3 for forward, w3^w2 for inverse) and the XOR chain.
- The top module holds the FSM, rcnt, key reg, rk10 reg and pass_done.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, load, rk_ready=1 -> after 10 edges rk_valid=1, rk_round=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6; next edge rk_round=9, rk_out=ac7766f319fadc2128d12941575c006e; round 1 rk_out=a0fafe1788542cb123a339392a6c7605; round 0 rk_out=key_in.
- Key 000102030405060708090a0b0c0d0e0f, AUTO_REWIND=1 -> round 10 rk_out=13111d7fe3944a17f307a78b4d2b30c5; after round 0 accepted pass_done pulses once and rk_round=10 with the same key.
- Random rk_ready throttling (~50%) -> each key held stable while rk_ready=0; sequence 10..0 exactly, no skips or duplicates; output matches a reference model.
- key_load at EXPAND cycle 5, and again mid-STREAM at round 4 -> restart with the new key; rk_valid low for exactly 10 cycles; no pass_done from the aborted pass.
- Async reset asserted mid-STREAM, off clock edge -> all outputs 0 immediately; after release, rk_valid stays 0 until the next key_load.
- AUTO_REWIND=0 -> after round 0 is accepted, rk_valid=0, busy=0, IDLE; further rk_ready has no effect.
